// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch stage.
// FSM states for the PC-to-instruction sequencer.
package fetch_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH0  = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_FETCH1  = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;

  localparam int FETCH_MAX_BYTES = 2;

endpackage

// File: rtl/fetch_mem_reader.sv
// Single memory read: registered request, ack capture and timeout.
// done/data/fault are valid only on the capture edge.
module fetch_mem_reader
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic              fault,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_do_ack,
  input  logic [DATA_W-1:0] mem_do
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);

  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              expire;

  // A timeout of zero never expires.
  assign expire = (MEM_TIMEOUT != 0) &&
                  (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  assign done  = mem_en_q && (mem_do_ack || expire);
  assign fault = mem_en_q && !mem_do_ack && expire;
  assign data  = fault ? '0 : mem_do;

  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
    end else if (start) begin
      mem_en_q   <= 1'b1;
      mem_addr_q <= addr;
      cnt_q      <= '0;
    end else if (done) begin
      mem_en_q   <= 1'b0;
    end else if (mem_en_q) begin
      cnt_q      <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: four-phase PC request in, one or two memory
// reads, instruction presented on the DOR/ack handshake.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int INSN_BYTES  = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_dir,
  input  logic [ADDR_W-1:0]            in_data,
  output logic                         in_ack,
  output logic                         out_dor,
  input  logic                         out_ack,
  output logic [DATA_W*INSN_BYTES-1:0] out_data,
  output logic                         out_fault,
  output logic                         mem_en,
  output logic                         mem_burst_en,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_di,
  input  logic                         mem_do_ack,
  input  logic [DATA_W-1:0]            mem_do
);

  localparam int OUT_W = DATA_W * INSN_BYTES;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              in_ack_q, in_ack_d;
  logic              pend_q, pend_d;
  logic [OUT_W-1:0]  insn_q, insn_d;
  logic              flt_q, flt_d;
  logic              dor_q, dor_d;
  logic              ofl_q, ofl_d;
  logic [OUT_W-1:0]  odat_q, odat_d;

  logic              rd_done;
  logic              rd_fault;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;

  // The second read is launched from GAP, so its address is PC+1.
  assign rd_addr = (state_q == S_GAP) ? pc_q + ADDR_W'(1) : pc_q;

  fetch_mem_reader #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_rd (
    .clk        (clk),
    .reset      (reset),
    .start      (pend_q),
    .addr       (rd_addr),
    .done       (rd_done),
    .data       (rd_data),
    .fault      (rd_fault),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_do_ack (mem_do_ack),
    .mem_do     (mem_do)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    in_ack_d = in_ack_q;
    pend_d   = pend_q;
    insn_d   = insn_q;
    flt_d    = flt_q;
    dor_d    = dor_q;
    ofl_d    = ofl_q;
    odat_d   = odat_q;
    if (!in_dir) in_ack_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_dir && !in_ack_q) begin
          pc_d     = in_data;
          in_ack_d = 1'b1;
          pend_d   = 1'b1;
          flt_d    = 1'b0;
          state_d  = S_FETCH0;
        end
      end
      S_FETCH0, S_FETCH1: begin
        pend_d = 1'b0;
        if (rd_done) begin
          state_d = S_PRESENT;
          if (rd_fault) begin
            insn_d = '0;
            flt_d  = 1'b1;
          end else if (state_q == S_FETCH1) begin
            insn_d = OUT_W'({rd_data, insn_q[DATA_W-1:0]});
          end else begin
            insn_d = OUT_W'(rd_data);
            if (INSN_BYTES == 2) begin
              state_d = S_GAP;
              pend_d  = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        pend_d  = 1'b0;
        state_d = S_FETCH1;
      end
      S_PRESENT: begin
        if (!dor_q) begin
          dor_d  = 1'b1;
          odat_d = insn_q;
          ofl_d  = flt_q;
        end else if (out_ack) begin
          dor_d   = 1'b0;
          ofl_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      in_ack_q <= 1'b0;
      pend_q   <= 1'b0;
      insn_q   <= '0;
      flt_q    <= 1'b0;
      dor_q    <= 1'b0;
      ofl_q    <= 1'b0;
      odat_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      in_ack_q <= in_ack_d;
      pend_q   <= pend_d;
      insn_q   <= insn_d;
      flt_q    <= flt_d;
      dor_q    <= dor_d;
      ofl_q    <= ofl_d;
      odat_q   <= odat_d;
    end
  end

  assign in_ack       = in_ack_q;
  assign out_dor      = dor_q;
  assign out_fault    = ofl_q;
  assign out_data     = odat_q;
  assign mem_burst_en = 1'b0;
  assign mem_di       = '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench: one-word stage with short timeout (a_*)
// and two-word stage (b_*).
module tb_fetch_stage;

  logic clk;
  logic reset;

  logic        a_in_dir, a_in_ack, a_out_dor, a_out_ack;
  logic [7:0]  a_in_data, a_out_data;
  logic        a_out_fault, a_mem_en, a_mem_burst_en, a_mem_do_ack;
  logic [7:0]  a_mem_addr, a_mem_di, a_mem_do;

  logic        b_in_dir, b_in_ack, b_out_dor, b_out_ack;
  logic [7:0]  b_in_data;
  logic [15:0] b_out_data;
  logic        b_out_fault, b_mem_en, b_mem_burst_en, b_mem_do_ack;
  logic [7:0]  b_mem_addr, b_mem_di, b_mem_do;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .ADDR_W(8), .DATA_W(8), .INSN_BYTES(1), .MEM_TIMEOUT(4)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .in_dir       (a_in_dir),
    .in_data      (a_in_data),
    .in_ack       (a_in_ack),
    .out_dor      (a_out_dor),
    .out_ack      (a_out_ack),
    .out_data     (a_out_data),
    .out_fault    (a_out_fault),
    .mem_en       (a_mem_en),
    .mem_burst_en (a_mem_burst_en),
    .mem_addr     (a_mem_addr),
    .mem_di       (a_mem_di),
    .mem_do_ack   (a_mem_do_ack),
    .mem_do       (a_mem_do)
  );

  fetch_stage #(
    .ADDR_W(8), .DATA_W(8), .INSN_BYTES(2), .MEM_TIMEOUT(16)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .in_dir       (b_in_dir),
    .in_data      (b_in_data),
    .in_ack       (b_in_ack),
    .out_dor      (b_out_dor),
    .out_ack      (b_out_ack),
    .out_data     (b_out_data),
    .out_fault    (b_out_fault),
    .mem_en       (b_mem_en),
    .mem_burst_en (b_mem_burst_en),
    .mem_addr     (b_mem_addr),
    .mem_di       (b_mem_di),
    .mem_do_ack   (b_mem_do_ack),
    .mem_do       (b_mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Zero-wait fetch on dut_a with full handshake checks.
  task automatic fetch_a(input logic [7:0] pc, input logic [7:0] d);
    a_in_dir  = 1'b1;
    a_in_data = pc;
    tick();
    chk("fa_ack", {31'd0, a_in_ack}, 32'd1);
    chk("fa_en0", {31'd0, a_mem_en}, 32'd0);
    a_in_dir = 1'b0;
    tick();
    chk("fa_en1", {23'd0, a_mem_en, a_mem_addr}, {23'd0, 1'b1, pc});
    chk("fa_ackdrop", {31'd0, a_in_ack}, 32'd0);
    a_mem_do_ack = 1'b1;
    a_mem_do     = d;
    tick();
    a_mem_do_ack = 1'b0;
    a_mem_do     = 8'h00;
    chk("fa_cap", {30'd0, a_mem_en, a_out_dor}, 32'd0);
    tick();
    chk("fa_out", {22'd0, a_out_dor, a_out_fault, a_out_data},
        {22'd0, 1'b1, 1'b0, d});
    chk("fa_noreack", {31'd0, a_in_ack}, 32'd0);
    a_out_ack = 1'b1;
    tick();
    a_out_ack = 1'b0;
    chk("fa_drop", {23'd0, a_out_dor, a_out_data}, {23'd0, 1'b0, d});
  endtask

  initial begin
    reset = 1'b1;
    a_in_dir = 0; a_in_data = 0; a_out_ack = 0;
    a_mem_do_ack = 0; a_mem_do = 0;
    b_in_dir = 0; b_in_data = 0; b_out_ack = 0;
    b_mem_do_ack = 0; b_mem_do = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_a_ctl", {26'd0, a_in_ack, a_out_dor, a_out_fault,
        a_mem_en, a_mem_burst_en, 1'b0}, 32'd0);
    chk("rst_a_dat", {8'd0, a_out_data, a_mem_addr, a_mem_di}, 32'd0);
    chk("rst_b", {b_out_data, b_mem_addr, 3'd0, b_in_ack,
        b_out_dor, b_out_fault, b_mem_en, b_mem_burst_en}, 32'd0);

    // Test 1: PC 0x01, ack two cycles after mem_en rises.
    a_in_dir  = 1'b1;
    a_in_data = 8'h01;
    tick();
    chk("t1_ack", {31'd0, a_in_ack}, 32'd1);
    a_in_dir = 1'b0;
    tick();
    chk("t1_en", {23'd0, a_mem_en, a_mem_addr}, {23'd0, 1'b1, 8'h01});
    tick();
    chk("t1_wait", {23'd0, a_mem_en, a_mem_addr}, {23'd0, 1'b1, 8'h01});
    a_mem_do_ack = 1'b1;
    a_mem_do     = 8'hA5;
    tick();
    a_mem_do_ack = 1'b0;
    a_mem_do     = 8'h00;
    chk("t1_enlow", {31'd0, a_mem_en}, 32'd0);
    tick();
    chk("t1_out", {22'd0, a_out_dor, a_out_fault, a_out_data},
        {22'd0, 1'b1, 1'b0, 8'hA5});
    chk("t1_onepulse", {31'd0, a_mem_en}, 32'd0);
    tick();
    chk("t1_hold", {31'd0, a_out_dor}, 32'd1);
    a_out_ack = 1'b1;
    tick();
    a_out_ack = 1'b0;
    chk("t1_drop", {23'd0, a_out_dor, a_out_data}, {23'd0, 1'b0, 8'hA5});

    // Test 2: stream of PCs 1..5.
    for (int i = 1; i <= 5; i++)
      fetch_a(8'(i), 8'(8'h10 + i));

    // Test 4: timeout after four mem_en cycles, then a clean fetch.
    a_in_dir  = 1'b1;
    a_in_data = 8'h20;
    tick();
    a_in_dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_en", {23'd0, a_mem_en, a_mem_addr}, {23'd0, 1'b1, 8'h20});
    end
    tick();
    chk("t4_enoff", {30'd0, a_mem_en, a_out_dor}, 32'd0);
    tick();
    chk("t4_fault", {22'd0, a_out_dor, a_out_fault, a_out_data},
        {22'd0, 1'b1, 1'b1, 8'h00});
    a_out_ack = 1'b1;
    tick();
    a_out_ack = 1'b0;
    chk("t4_clr", {30'd0, a_out_dor, a_out_fault}, 32'd0);
    fetch_a(8'h21, 8'h5C);

    // Test 5: in_dir held high, delayed out_ack, stray mem_do_ack.
    a_in_dir  = 1'b1;
    a_in_data = 8'h30;
    tick();
    chk("t5_ack", {31'd0, a_in_ack}, 32'd1);
    tick();
    a_mem_do_ack = 1'b1;
    a_mem_do     = 8'h77;
    tick();
    a_mem_do_ack = 1'b0;
    a_mem_do     = 8'h00;
    chk("t5_ackheld", {31'd0, a_in_ack}, 32'd1);
    tick();
    chk("t5_out", {23'd0, a_out_dor, a_out_data}, {23'd0, 1'b1, 8'h77});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold", {22'd0, a_out_dor, a_mem_en, a_out_data},
          {22'd0, 1'b1, 1'b0, 8'h77});
    end
    a_out_ack = 1'b1;
    tick();
    a_out_ack = 1'b0;
    chk("t5_drop", {31'd0, a_out_dor}, 32'd0);
    tick();
    chk("t5_noacc", {30'd0, a_in_ack, a_mem_en}, {30'd0, 1'b1, 1'b0});
    a_mem_do_ack = 1'b1;
    a_mem_do     = 8'hEE;
    tick();
    a_mem_do_ack = 1'b0;
    a_mem_do     = 8'h00;
    tick();
    chk("t5_stray", {22'd0, a_mem_en, a_out_dor, a_out_data},
        {22'd0, 1'b0, 1'b0, 8'h77});
    a_in_dir = 1'b0;
    tick();
    chk("t5_ackclr", {31'd0, a_in_ack}, 32'd0);
    tick();
    chk("t5_idle", {30'd0, a_mem_en, a_out_dor}, 32'd0);

    // Test 6: reset in the middle of FETCH0.
    a_in_dir  = 1'b1;
    a_in_data = 8'h40;
    tick();
    a_in_dir = 1'b0;
    tick();
    chk("t6_en", {31'd0, a_mem_en}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_ctl", {28'd0, a_in_ack, a_out_dor, a_out_fault, a_mem_en},
        32'd0);
    chk("t6_rst_dat", {16'd0, a_out_data, a_mem_addr}, 32'd0);
    reset = 1'b0;
    tick();
    chk("t6_quiet", {31'd0, a_mem_en}, 32'd0);
    fetch_a(8'h07, 8'h99);

    // Test 3: two-word fetch wrapping 0xFF -> 0x00.
    b_in_dir  = 1'b1;
    b_in_data = 8'hFF;
    tick();
    chk("t3_ack", {31'd0, b_in_ack}, 32'd1);
    b_in_dir = 1'b0;
    tick();
    chk("t3_rd0", {23'd0, b_mem_en, b_mem_addr}, {23'd0, 1'b1, 8'hFF});
    b_mem_do_ack = 1'b1;
    b_mem_do     = 8'h12;
    tick();
    b_mem_do_ack = 1'b0;
    b_mem_do     = 8'h00;
    chk("t3_gap", {31'd0, b_mem_en}, 32'd0);
    tick();
    chk("t3_rd1", {23'd0, b_mem_en, b_mem_addr}, {23'd0, 1'b1, 8'h00});
    b_mem_do_ack = 1'b1;
    b_mem_do     = 8'h34;
    tick();
    b_mem_do_ack = 1'b0;
    b_mem_do     = 8'h00;
    chk("t3_end", {30'd0, b_mem_en, b_out_dor}, 32'd0);
    tick();
    chk("t3_out", {14'd0, b_out_dor, b_out_fault, b_out_data},
        {14'd0, 1'b1, 1'b0, 16'h3412});
    b_out_ack = 1'b1;
    tick();
    b_out_ack = 1'b0;
    chk("t3_drop", {15'd0, b_out_dor, b_out_data}, {15'd0, 1'b0, 16'h3412});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
